// File: rtl/sdram_initiator.sv
// Bridges 16-bit CPU requests onto a 64-bit SDRAM line interface, with an optional
// single-line read buffer that serves hits locally and is kept coherent by write-through merges.
module sdram_initiator #(
  parameter int LINE_BUF_EN = 1
) (
  input  logic        clk_clk,
  input  logic        reset_reset,
  input  logic [17:0] cpu_address,
  input  logic        cpu_read,
  input  logic        cpu_write,
  input  logic [1:0]  cpu_byte_enable,
  input  logic [15:0] cpu_write_data,
  output logic        cpu_ready,
  output logic [15:0] cpu_read_data,
  output logic        cpu_read_valid,
  output logic        cpu_write_done,
  input  logic        flush,
  output logic [15:0] sdram_address,
  output logic [7:0]  sdram_byte_enable,
  output logic        sdram_read,
  output logic        sdram_write,
  output logic [63:0] sdram_write_data,
  input  logic        sdram_acknowledge,
  input  logic [63:0] sdram_read_data,
  output logic [1:0]  debug_state
);

  // Handshake: a request is taken on any rising edge where cpu_ready and (cpu_read or
  // cpu_write) are high; SDRAM strobes stay high until sdram_acknowledge is sampled high.
  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, RESP} state_t;

  localparam logic BUF_ON = (LINE_BUF_EN != 0);

  state_t      state;
  state_t      next_state;
  logic        accept_wr;
  logic        accept_rd;
  logic        hit;
  logic [1:0]  lane;
  logic [1:0]  lane_q;
  logic [63:0] buf_line;
  logic [15:0] buf_tag;
  logic        buf_valid;

  assign lane = cpu_address[1:0];

  always_comb begin
    cpu_ready      = (state == IDLE);
    accept_wr      = cpu_ready && cpu_write;
    accept_rd      = cpu_ready && cpu_read && !cpu_write;
    hit            = BUF_ON && buf_valid && (buf_tag == cpu_address[17:2]);
    sdram_read     = (state == RD_WAIT);
    sdram_write    = (state == WR_WAIT);
    cpu_read_valid = (state == RESP);
    debug_state    = state;
    next_state     = state;
    case (state)
      IDLE: begin
        if (accept_wr)      next_state = WR_WAIT;
        else if (accept_rd) next_state = hit ? RESP : RD_WAIT;
      end
      RD_WAIT: if (sdram_acknowledge) next_state = RESP;
      WR_WAIT: if (sdram_acknowledge) next_state = IDLE;
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) state <= IDLE;
    else             state <= next_state;
  end

  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      sdram_address     <= '0;
      sdram_byte_enable <= '0;
      sdram_write_data  <= '0;
      cpu_read_data     <= '0;
      cpu_write_done    <= 1'b0;
      lane_q            <= '0;
      buf_line          <= '0;
      buf_tag           <= '0;
      buf_valid         <= 1'b0;
    end else begin
      cpu_write_done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept_wr) begin
            sdram_address     <= cpu_address[17:2];
            sdram_write_data  <= {4{cpu_write_data}};
            sdram_byte_enable <= 8'(cpu_byte_enable) << {lane, 1'b0};
          end else if (accept_rd) begin
            lane_q <= lane;
            if (hit) begin
              cpu_read_data <= buf_line[{lane, 4'b0000} +: 16];
            end else begin
              sdram_address     <= cpu_address[17:2];
              sdram_byte_enable <= 8'hFF;
            end
          end
        end
        RD_WAIT: begin
          if (sdram_acknowledge) begin
            cpu_read_data <= sdram_read_data[{lane_q, 4'b0000} +: 16];
            buf_line      <= sdram_read_data;
            buf_tag       <= sdram_address;
            buf_valid     <= BUF_ON;
          end
        end
        WR_WAIT: begin
          if (sdram_acknowledge) begin
            cpu_write_done <= 1'b1;
            // Write-through: keep the buffered copy identical to SDRAM.
            if (buf_valid && (buf_tag == sdram_address)) begin
              for (int i = 0; i < 8; i++) begin
                if (sdram_byte_enable[i]) buf_line[8*i +: 8] <= sdram_write_data[8*i +: 8];
              end
            end
          end
        end
        default: ;
      endcase
      // Placed last so an invalidate overrides a fill or merge in the same cycle.
      if (flush) buf_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_sdram_initiator.sv
// Directed bench for sdram_initiator: a table of CPU transactions with hand-computed
// SDRAM-side and CPU-side results, plus sequences for dual request, flush-on-fill and reset.
module tb_sdram_initiator;

  logic        clk_clk;
  logic        reset_reset;
  logic [17:0] cpu_address;
  logic        cpu_read;
  logic        cpu_write;
  logic [1:0]  cpu_byte_enable;
  logic [15:0] cpu_write_data;
  logic        cpu_ready;
  logic [15:0] cpu_read_data;
  logic        cpu_read_valid;
  logic        cpu_write_done;
  logic        flush;
  logic [15:0] sdram_address;
  logic [7:0]  sdram_byte_enable;
  logic        sdram_read;
  logic        sdram_write;
  logic [63:0] sdram_write_data;
  logic        sdram_acknowledge;
  logic [63:0] sdram_read_data;
  logic [1:0]  debug_state;

  sdram_initiator #(.LINE_BUF_EN(1)) dut (
    .clk_clk           (clk_clk),
    .reset_reset       (reset_reset),
    .cpu_address       (cpu_address),
    .cpu_read          (cpu_read),
    .cpu_write         (cpu_write),
    .cpu_byte_enable   (cpu_byte_enable),
    .cpu_write_data    (cpu_write_data),
    .cpu_ready         (cpu_ready),
    .cpu_read_data     (cpu_read_data),
    .cpu_read_valid    (cpu_read_valid),
    .cpu_write_done    (cpu_write_done),
    .flush             (flush),
    .sdram_address     (sdram_address),
    .sdram_byte_enable (sdram_byte_enable),
    .sdram_read        (sdram_read),
    .sdram_write       (sdram_write),
    .sdram_write_data  (sdram_write_data),
    .sdram_acknowledge (sdram_acknowledge),
    .sdram_read_data   (sdram_read_data),
    .debug_state       (debug_state)
  );

  // Clock and reset
  initial clk_clk = 1'b0;
  always #5 clk_clk = ~clk_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, actual=running required=finished");
    $fatal(1);
  end

  // Scoreboard
  int          n_total = 0;
  int          n_pass  = 0;
  int          wd_seen = 0;
  int          wd_exp  = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
  endtask

  always @(negedge clk_clk) begin
    if (!reset_reset) begin
      if (cpu_read_valid) begin
        if (exp_q.size() == 0) check("spurious_read_valid", cpu_read_valid, 1'b0);
        else                   check("read_data", cpu_read_data, exp_q.pop_front());
      end
      if (cpu_write_done) wd_seen++;
    end
  end

  typedef struct {
    bit          is_wr;
    logic [17:0] addr;
    logic [1:0]  be;
    logic [15:0] wdata;
    int          dly;
    logic [63:0] ack_data;
    bit          miss;
    logic [15:0] exp_saddr;
    logic [7:0]  exp_sbe;
    logic [63:0] exp_swdata;
    logic [15:0] exp_rdata;
    bit          flush_ack;
  } vec_t;

  function automatic vec_t mk(bit is_wr, logic [17:0] addr, logic [1:0] be, logic [15:0] wdata,
                              int dly, logic [63:0] ack_data, bit miss, logic [15:0] sa,
                              logic [7:0] sbe, logic [63:0] swd, logic [15:0] rd, bit fl);
    vec_t v;
    v.is_wr = is_wr; v.addr = addr; v.be = be; v.wdata = wdata; v.dly = dly;
    v.ack_data = ack_data; v.miss = miss; v.exp_saddr = sa; v.exp_sbe = sbe;
    v.exp_swdata = swd; v.exp_rdata = rd; v.flush_ack = fl;
    return v;
  endfunction

  // Driver: one CPU transaction, with the SDRAM side answered after v.dly wait cycles.
  task automatic run_txn(input vec_t v);
    @(negedge clk_clk);
    check("ready_before", cpu_ready, 1'b1);
    cpu_address     = v.addr;
    cpu_byte_enable = v.be;
    cpu_write_data  = v.wdata;
    cpu_read        = !v.is_wr;
    cpu_write       = v.is_wr;
    if (v.is_wr) wd_exp++;
    else         exp_q.push_back(v.exp_rdata);
    @(negedge clk_clk);
    cpu_read  = 1'b0;
    cpu_write = 1'b0;
    cpu_address = 18'($urandom_range(0, 18'h3FFFF));
    if (v.miss) begin
      check("strobe_rd", sdram_read, !v.is_wr);
      check("strobe_wr", sdram_write, v.is_wr);
      check("sdram_address", sdram_address, v.exp_saddr);
      check("sdram_byte_enable", sdram_byte_enable, v.exp_sbe);
      if (v.is_wr) check("sdram_write_data", sdram_write_data, v.exp_swdata);
      for (int i = 0; i < v.dly; i++) begin
        @(negedge clk_clk);
        check("strobe_hold", v.is_wr ? sdram_write : sdram_read, 1'b1);
        check("address_hold", sdram_address, v.exp_saddr);
      end
      sdram_acknowledge = 1'b1;
      sdram_read_data   = v.ack_data;
      flush             = v.flush_ack;
      @(negedge clk_clk);
      sdram_acknowledge = 1'b0;
      flush             = 1'b0;
      sdram_read_data   = {$urandom(), $urandom()};
      check("strobe_drop", {sdram_read, sdram_write}, 2'b00);
      if (v.is_wr) check("write_done", cpu_write_done, 1'b1);
      else         check("miss_read_valid", cpu_read_valid, 1'b1);
    end else begin
      check("hit_no_sdram_read", sdram_read, 1'b0);
      check("hit_latency", cpu_read_valid, 1'b1);
    end
  endtask

  vec_t vecs[10];

  initial begin
    reset_reset = 1'b1;
    cpu_address = '0; cpu_read = 1'b0; cpu_write = 1'b0;
    cpu_byte_enable = '0; cpu_write_data = '0; flush = 1'b0;
    sdram_acknowledge = 1'b0; sdram_read_data = '0;

    vecs[0] = mk(0, 18'h00005, 2'b00, 16'h0000, 3, 64'h4444_3333_2222_1111, 1, 16'h0001, 8'hFF, 64'h0, 16'h2222, 0);
    vecs[1] = mk(0, 18'h00007, 2'b00, 16'h0000, 0, 64'h0, 0, 16'h0, 8'h0, 64'h0, 16'h4444, 0);
    vecs[2] = mk(1, 18'h00006, 2'b01, 16'hABCD, 1, 64'h0, 1, 16'h0001, 8'h10, {4{16'hABCD}}, 16'h0, 0);
    vecs[3] = mk(0, 18'h00006, 2'b00, 16'h0000, 0, 64'h0, 0, 16'h0, 8'h0, 64'h0, 16'h33CD, 0);
    vecs[4] = mk(1, 18'h00013, 2'b11, 16'h5A5A, 0, 64'h0, 1, 16'h0004, 8'hC0, {4{16'h5A5A}}, 16'h0, 0);
    vecs[5] = mk(0, 18'h00004, 2'b00, 16'h0000, 0, 64'h0, 0, 16'h0, 8'h0, 64'h0, 16'h1111, 0);
    vecs[6] = mk(0, 18'h3FFFE, 2'b00, 16'h0000, 2, 64'h0123_4567_89AB_CDEF, 1, 16'hFFFF, 8'hFF, 64'h0, 16'h4567, 0);
    vecs[7] = mk(1, 18'h3FFFD, 2'b10, 16'h9876, 0, 64'h0, 1, 16'hFFFF, 8'h08, {4{16'h9876}}, 16'h0, 0);
    vecs[8] = mk(0, 18'h3FFFD, 2'b00, 16'h0000, 0, 64'h0, 0, 16'h0, 8'h0, 64'h0, 16'h98AB, 0);
    vecs[9] = mk(0, 18'h00005, 2'b00, 16'h0000, 0, 64'hDEAD_BEEF_CAFE_F00D, 1, 16'h0001, 8'hFF, 64'h0, 16'hCAFE, 0);

    // Reset state
    repeat (2) @(negedge clk_clk);
    check("rst_ready", cpu_ready, 1'b1);
    check("rst_strobes", {sdram_read, sdram_write}, 2'b00);
    check("rst_sdram_address", sdram_address, 16'h0);
    check("rst_sdram_be", sdram_byte_enable, 8'h0);
    check("rst_sdram_wdata", sdram_write_data, 64'h0);
    check("rst_read_data", cpu_read_data, 16'h0);
    check("rst_pulses", {cpu_read_valid, cpu_write_done}, 2'b00);
    reset_reset = 1'b0;

    for (int i = 0; i < 10; i++) run_txn(vecs[i]);

    // Read and write together: only the write goes out.
    @(negedge clk_clk);
    cpu_address = 18'h00009; cpu_byte_enable = 2'b11; cpu_write_data = 16'h1234;
    cpu_read = 1'b1; cpu_write = 1'b1;
    wd_exp++;
    @(negedge clk_clk);
    cpu_read = 1'b0; cpu_write = 1'b0;
    check("dual_sdram_write", sdram_write, 1'b1);
    check("dual_no_sdram_read", sdram_read, 1'b0);
    check("dual_address", sdram_address, 16'h0002);
    check("dual_be", sdram_byte_enable, 8'h0C);
    check("dual_wdata", sdram_write_data, {4{16'h1234}});
    sdram_acknowledge = 1'b1;
    @(negedge clk_clk);
    sdram_acknowledge = 1'b0;
    check("dual_write_done", cpu_write_done, 1'b1);
    check("dual_no_read_valid", cpu_read_valid, 1'b0);

    // Flush in the fill cycle: data still returned, line not retained.
    run_txn(mk(0, 18'h00008, 2'b00, 16'h0, 1, 64'h8888_7777_6666_5555, 1, 16'h0002, 8'hFF, 64'h0, 16'h5555, 1));
    run_txn(mk(0, 18'h0000A, 2'b00, 16'h0, 0, 64'h1111_2222_3333_4444, 1, 16'h0002, 8'hFF, 64'h0, 16'h2222, 0));
    run_txn(mk(0, 18'h0000B, 2'b00, 16'h0, 0, 64'h0, 0, 16'h0, 8'h0, 64'h0, 16'h1111, 0));

    // Reset while waiting on SDRAM, acknowledge arrives afterwards.
    @(negedge clk_clk);
    cpu_address = 18'h0000C; cpu_read = 1'b1;
    @(negedge clk_clk);
    cpu_read = 1'b0;
    check("rstw_strobe", sdram_read, 1'b1);
    @(negedge clk_clk);
    reset_reset = 1'b1;
    #1;
    check("rstw_strobe_drop", {sdram_read, sdram_write}, 2'b00);
    check("rstw_ready", cpu_ready, 1'b1);
    check("rstw_no_valid", cpu_read_valid, 1'b0);
    check("rstw_address", sdram_address, 16'h0);
    @(negedge clk_clk);
    reset_reset = 1'b0;
    @(negedge clk_clk);
    sdram_acknowledge = 1'b1;
    sdram_read_data   = 64'h5A5A_5A5A_5A5A_5A5A;
    @(negedge clk_clk);
    sdram_acknowledge = 1'b0;
    check("late_ack_no_valid", cpu_read_valid, 1'b0);
    check("late_ack_no_strobe", sdram_read, 1'b0);
    check("late_ack_ready", cpu_ready, 1'b1);
    check("late_ack_read_data", cpu_read_data, 16'h0);
    // Buffer was invalidated by reset, so the previously hit line misses.
    run_txn(mk(0, 18'h0000B, 2'b00, 16'h0, 0, 64'hAAAA_BBBB_CCCC_DDDD, 1, 16'h0002, 8'hFF, 64'h0, 16'hAAAA, 0));

    repeat (2) @(negedge clk_clk);
    check("exp_q_drained", 64'(exp_q.size()), 64'h0);
    check("write_done_count", 64'(wd_seen), 64'(wd_exp));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/sdram_initiator.md
SDRAM_INITIATOR -- requirements
Module: sdram_initiator

Interface
REQ-001 SHALL have parameter LINE_BUF_EN, default 1, meaning 1 = single-line read buffer present and 0 = every read goes to SDRAM.
REQ-002 SHALL have one clock; reset is asynchronous and active-high.
REQ-003 SHALL have port clk_clk, input, 1 bit: the single clock; all logic on its rising edge.
REQ-004 SHALL have port reset_reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port cpu_address, input, 18 bits: 16-bit-word address; [17:2] selects the line, [1:0] selects the lane.
REQ-006 SHALL have port cpu_read, input, 1 bit: read request.
REQ-007 SHALL have port cpu_write, input, 1 bit: write request.
REQ-008 SHALL have port cpu_byte_enable, input, 2 bits: byte mask for writes; ignored for reads.
REQ-009 SHALL have port cpu_write_data, input, 16 bits: write data.
REQ-010 SHALL have port cpu_ready, output, 1 bit: request accepted this cycle when high.
REQ-011 SHALL have port cpu_read_data, output, 16 bits: read data.
REQ-012 SHALL have port cpu_read_valid, output, 1 bit: one-cycle pulse qualifying cpu_read_data.
REQ-013 SHALL have port cpu_write_done, output, 1 bit: one-cycle pulse marking write completion.
REQ-014 SHALL have port flush, input, 1 bit: invalidate the line buffer.
REQ-015 SHALL have port sdram_address, output, 16 bits: 64-bit line address.
REQ-016 SHALL have port sdram_byte_enable, output, 8 bits: byte lanes of the 64-bit line.
REQ-017 SHALL have port sdram_read, output, 1 bit: read strobe, held until acknowledge.
REQ-018 SHALL have port sdram_write, output, 1 bit: write strobe, held until acknowledge.
REQ-019 SHALL have port sdram_write_data, output, 64 bits: write data.
REQ-020 SHALL have port sdram_acknowledge, input, 1 bit: transfer complete.
REQ-021 SHALL have port sdram_read_data, input, 64 bits: read data, valid in the acknowledge cycle.

Function
REQ-022 SHALL implement states IDLE, RD_WAIT, WR_WAIT and RESP.
REQ-023 SHALL drive cpu_ready high only in IDLE, combinationally.
REQ-024 SHALL accept a request when cpu_ready is high and (cpu_read or cpu_write) is high.
REQ-025 SHALL give cpu_write priority when cpu_read and cpu_write are both high; the read is dropped.
REQ-026 SHALL, on an accepted write in IDLE, go to WR_WAIT and register the following:
  - sdram_address = cpu_address[17:2];
  - sdram_write_data = cpu_write_data replicated ×4;
  - sdram_byte_enable = cpu_byte_enable placed at bits [2k+1:2k] (k = cpu_address[1:0]), zeros elsewhere.
REQ-027 SHALL, on an accepted read that hits (LINE_BUF_EN=1, buffer valid, tag == cpu_address[17:2]), go to RESP with no SDRAM access.
REQ-028 SHALL, on an accepted read that misses, go to RD_WAIT and register the following:
  - sdram_address;
  - sdram_byte_enable = 8'hFF (full line).
REQ-029 SHALL keep sdram_read/sdram_write high continuously in RD_WAIT/WR_WAIT, with address, byte enable and data stable, until sdram_acknowledge is sampled high.
REQ-030 SHALL deassert the strobe in the cycle after the acknowledge is sampled.
REQ-031 SHALL, on acknowledge in RD_WAIT, do the following:
  - latch sdram_read_data[16k+15:16k] into cpu_read_data;
  - latch the line and tag into the buffer and set it valid;
  - go to RESP.
REQ-032 SHALL pulse cpu_read_valid high for exactly one cycle in RESP, then return to IDLE.
REQ-033 SHALL, on acknowledge in WR_WAIT, do the following:
  - pulse cpu_write_done high for exactly one cycle (the next cycle);
  - return to IDLE;
  - if the buffer holds the same line and is valid, merge the written bytes into it (write-through).
REQ-034 SHALL set read latency as follows, where N = accept cycle:
  - hit: cpu_read_valid at N+1;
  - miss: cpu_read_valid one cycle after the acknowledge cycle.
REQ-035 SHALL ignore sdram_acknowledge outside RD_WAIT/WR_WAIT.
REQ-036 SHALL clear the buffer valid bit when flush is high; flush wins over a fill or merge in the same cycle, and the CPU still receives its data.
REQ-037 SHALL keep cpu_read_data holding its last value between pulses.
REQ-038 SHALL, with LINE_BUF_EN=0, treat every read as a miss and keep the valid bit at 0.

Reset
REQ-039 SHALL, while reset_reset is high, force the following immediately:
  - state = IDLE;
  - sdram_read = sdram_write = 0;
  - sdram_address = 0, sdram_byte_enable = 0, sdram_write_data = 0;
  - cpu_read_data = 0, cpu_read_valid = cpu_write_done = 0;
  - buffer valid = 0.
REQ-040 SHALL, on reset mid-transaction, abandon the transaction with no completion pulse; a late acknowledge is ignored.

Verification
REQ-041 SHALL cover a read miss:
  - stimulus: read 18'h00005, acknowledge 3 cycles later with data 64'h4444_3333_2222_1111;
  - response: sdram_address = 16'h0001, byte enable = 8'hFF, cpu_read_data = 16'h2222, one cpu_read_valid pulse.
REQ-042 SHALL cover a read hit:
  - stimulus: after REQ-041, read 18'h00007;
  - response: no sdram_read, cpu_read_valid at N+1, data = 16'h4444.
REQ-043 SHALL cover a write hit:
  - stimulus: write 18'h00006, byte enable 2'b01, data 16'hABCD, then read 18'h00006;
  - response: sdram_byte_enable = 8'h10, sdram_write_data = 16'hABCD ×4, one cpu_write_done pulse, hit returns 16'h33CD.
REQ-044 SHALL cover read and write asserted together:
  - stimulus: cpu_read and cpu_write both high;
  - response: only sdram_write is issued.
REQ-045 SHALL cover flush in the fill cycle:
  - stimulus: flush high in the acknowledge cycle of a miss;
  - response: data is returned, and the next read of the same line goes to SDRAM.
REQ-046 SHALL cover reset in RD_WAIT:
  - stimulus: reset asserted in RD_WAIT, acknowledge arrives after reset is released;
  - response: strobes drop at once, no cpu_read_valid pulse, cpu_ready = 1.
